// File: rtl/store_merge_unit.sv
// ============================================================================
// store_merge_unit
// ----------------------------------------------------------------------------
// Handles store requests from the multicycle control unit and writes
// sd/sw/sh/sb into a 64-bit doubleword data memory.
//
// Default build: sub-doubleword stores use read-modify-write. The unit reads
// the aligned doubleword, merges the new lane into it and writes it back.
// Doubleword stores go straight to a write.
//
// Optional feature macro: STORE_MERGE_BYTE_EN_EN
//   When defined, the unit adds the mem_be byte-enable port. Every store size
//   then goes straight to a write with lane-shifted data and byte enables, and
//   mem_rd is never asserted.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     store request handshake (ready only in IDLE)
//   req_size            00=sd 01=sw 10=sh 11=sb
//   req_addr/req_wdata  byte address, right-justified store data
//   done, err           one-cycle completion pulse; err set with done when
//                       the request is misaligned
//   mem_addr            doubleword-aligned address, held while busy
//   mem_rd, mem_rdata   read strobe; read data arrives MEM_LAT cycles later
//   mem_wr, mem_wdata   write strobe and write data (data zero otherwise)
//   mem_be              byte enables (only with STORE_MERGE_BYTE_EN_EN)
//   dbg_state           current FSM state, for observation
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The request is not queued. While the unit is busy, req_ready is 0 and
// requests are dropped.
// ============================================================================
module store_merge_unit #(
    parameter int unsigned MEM_LAT = 1     // 1..7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    input  logic [63:0] mem_rdata,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
`ifdef STORE_MERGE_BYTE_EN_EN
    output logic [7:0]  mem_be,
`endif
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    // Mask of the low N bits for each store size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            2'b01:   size_mask = 64'h0000_0000_FFFF_FFFF;
            2'b10:   size_mask = 64'h0000_0000_0000_FFFF;
            default: size_mask = 64'h0000_0000_0000_00FF;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        misaligned;

`ifdef STORE_MERGE_BYTE_EN_EN
    logic [7:0]  be_q, be_d;
    logic [7:0]  be_base;
`else
    logic [2:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] data_q, data_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
`endif

    always_comb begin
        case (req_size)
            2'b00:   misaligned = (req_addr[2:0] != 3'b000);
            2'b01:   misaligned = (req_addr[1:0] != 2'b00);
            2'b10:   misaligned = req_addr[0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef STORE_MERGE_BYTE_EN_EN
    always_comb begin
        case (req_size)
            2'b00:   be_base = 8'hFF;
            2'b01:   be_base = 8'h0F;
            2'b10:   be_base = 8'h03;
            default: be_base = 8'h01;
        endcase
    end
`else
    // The lane that gets replaced sits at byte offset off. Its mask and the
    // new data are both shifted into place.
    always_comb begin
        lane_mask = size_mask(size_q) << {off_q, 3'b000};
        lane_data = (data_q & size_mask(size_q)) << {off_q, 3'b000};
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef STORE_MERGE_BYTE_EN_EN
        be_d    = be_q;
`else
        off_d   = off_q;
        size_d  = size_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = {req_addr[63:3], 3'b000};
`ifdef STORE_MERGE_BYTE_EN_EN
                    wdata_d = (req_wdata & size_mask(req_size)) << {req_addr[2:0], 3'b000};
                    be_d    = be_base << req_addr[2:0];
                    state_d = misaligned ? S_ERR : S_WRITE;
`else
                    off_d  = req_addr[2:0];
                    size_d = req_size;
                    data_d = req_wdata;
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else if (req_size == 2'b00) begin
                        wdata_d = req_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
`endif
                end
            end
`ifndef STORE_MERGE_BYTE_EN_EN
            S_READ: begin
                cnt_d   = 3'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The read data is captured on the edge that ends the last wait cycle.
                if (cnt_q == LAST_WAIT) begin
                    wdata_d = (mem_rdata & ~lane_mask) | lane_data;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`endif
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef STORE_MERGE_BYTE_EN_EN
            be_q    <= '0;
`else
            off_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef STORE_MERGE_BYTE_EN_EN
            be_q    <= be_d;
`else
            off_q   <= off_d;
            size_q  <= size_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // All outputs are decoded from the registered state. A reset therefore
    // clears the strobes immediately.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        mem_rd    = (state_q == S_READ);
        mem_wr    = (state_q == S_WRITE);
        done      = (state_q == S_DONE) || (state_q == S_ERR);
        err       = (state_q == S_ERR);
        mem_addr  = addr_q;
        mem_wdata = (state_q == S_WRITE) ? wdata_q : 64'd0;
`ifdef STORE_MERGE_BYTE_EN_EN
        mem_be    = (state_q == S_WRITE) ? be_q : 8'd0;
`endif
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;

    // dut1: MEM_LAT=1, dut3: MEM_LAT=3. Both instances share the request inputs.
    logic        rdy1, done1, err1, rd1, wr1, rdy3, done3, err3, rd3, wr3;
    logic [63:0] addr1, wdata1, rdata1, addr3, wdata3, rdata3;
    logic [7:0]  be1, be3;
    logic [2:0]  st1, st3;
    logic [63:0] mem_val1 = 64'd0;
    logic [63:0] mem_val3 = 64'd0;
    logic        pipe1 = 1'b0;
    logic [2:0]  pipe3 = 3'd0;

    int n_cmp = 0;
    int n_fail = 0;

    logic        cap_rd[0:15], cap_wr[0:15], cap_done[0:15], cap_err[0:15], cap_rdy[0:15];
    logic [63:0] cap_addr[0:15], cap_wdata[0:15];
    logic [7:0]  cap_be[0:15];

    always #5 clk = ~clk;

    store_merge_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy1),
        .done(done1), .err(err1), .mem_addr(addr1), .mem_rd(rd1),
        .mem_rdata(rdata1), .mem_wr(wr1), .mem_wdata(wdata1),
`ifdef STORE_MERGE_BYTE_EN_EN
        .mem_be(be1),
`endif
        .dbg_state(st1)
    );

    store_merge_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy3),
        .done(done3), .err(err3), .mem_addr(addr3), .mem_rd(rd3),
        .mem_rdata(rdata3), .mem_wr(wr3), .mem_wdata(wdata3),
`ifdef STORE_MERGE_BYTE_EN_EN
        .mem_be(be3),
`endif
        .dbg_state(st3)
    );

`ifndef STORE_MERGE_BYTE_EN_EN
    assign be1 = 8'd0;
    assign be3 = 8'd0;
`endif

    // Memory models: read data is valid only in the cycle exactly MEM_LAT
    // cycles after mem_rd. Any other cycle returns garbage.
    always @(posedge clk) begin
        pipe1 <= rd1;
        pipe3 <= {pipe3[1:0], rd3};
    end
    assign rdata1 = pipe1    ? mem_val1 : 64'hDEAD_BEEF_DEAD_BEEF;
    assign rdata3 = pipe3[2] ? mem_val3 : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] size, input logic [63:0] addr, input logic [63:0] data);
        req_valid = 1'b1;
        req_size  = size;
        req_addr  = addr;
        req_wdata = data;
    endtask

    // Cycle c of the capture is the c-th cycle after acceptance edge T.
    task automatic capture(input int sel, input int n, input bit hold);
        for (int c = 1; c <= n; c++) begin
            tick();
            if (!hold && c == 1) req_valid = 1'b0;
            cap_rd[c]    = sel ? rd3 : rd1;
            cap_wr[c]    = sel ? wr3 : wr1;
            cap_done[c]  = sel ? done3 : done1;
            cap_err[c]   = sel ? err3 : err1;
            cap_rdy[c]   = sel ? rdy3 : rdy1;
            cap_addr[c]  = sel ? addr3 : addr1;
            cap_wdata[c] = sel ? wdata3 : wdata1;
            cap_be[c]    = sel ? be3 : be1;
        end
        req_valid = 1'b0;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!(rdy1 && rdy3) && k < 20) begin
            tick();
            k++;
        end
        n_cmp++; if (!(rdy1 && rdy3)) begin n_fail++; $display("FAIL settle_timeout: rdy1=%0b rdy3=%0b want 1/1", rdy1, rdy3); end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", rdy1); end
        n_cmp++; if ({done1, err1, rd1, wr1} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {done1, err1, rd1, wr1}); end
        n_cmp++; if ({addr1, wdata1} !== 128'd0) begin n_fail++; $display("FAIL rst_addr_data: got %h %h want 0", addr1, wdata1); end
        n_cmp++; if (st1 !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", st1); end
        n_cmp++; if (be1 !== 8'd0) begin n_fail++; $display("FAIL rst_be: got %h want 00", be1); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sd();
        drive(2'b00, 64'h10, 64'h1122334455667788);
        capture(0, 3, 1'b0);
        n_cmp++; if (cap_wr[1] !== 1'b1 || cap_rd[1] !== 1'b0) begin n_fail++; $display("FAIL sd_wr_t1: wr=%0b rd=%0b want 1/0", cap_wr[1], cap_rd[1]); end
        n_cmp++; if (cap_addr[1] !== 64'h10) begin n_fail++; $display("FAIL sd_addr: got %h want 10", cap_addr[1]); end
        n_cmp++; if (cap_wdata[1] !== 64'h1122334455667788) begin n_fail++; $display("FAIL sd_wdata: got %h want 1122334455667788", cap_wdata[1]); end
        n_cmp++; if (cap_done[2] !== 1'b1 || cap_wr[2] !== 1'b0 || cap_err[2] !== 1'b0) begin n_fail++; $display("FAIL sd_done_t2: done=%0b wr=%0b err=%0b want 1/0/0", cap_done[2], cap_wr[2], cap_err[2]); end
        n_cmp++; if (cap_rdy[3] !== 1'b1 || cap_rd[2] !== 1'b0) begin n_fail++; $display("FAIL sd_idle_t3: ready=%0b rd=%0b want 1/0", cap_rdy[3], cap_rd[2]); end
`ifdef STORE_MERGE_BYTE_EN_EN
        n_cmp++; if (cap_be[1] !== 8'hFF) begin n_fail++; $display("FAIL sd_be: got %h want FF", cap_be[1]); end
`endif
        settle();
    endtask

`ifndef STORE_MERGE_BYTE_EN_EN
    task automatic test_sb_lat1();
        mem_val1 = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(2'b11, 64'h13, 64'h0000_0000_0000_00AB);
        capture(0, 5, 1'b0);
        n_cmp++; if (cap_rd[1] !== 1'b1 || cap_addr[1] !== 64'h10) begin n_fail++; $display("FAIL sb_rd_t1: rd=%0b addr=%h want 1/10", cap_rd[1], cap_addr[1]); end
        n_cmp++; if (cap_wr[2] !== 1'b0 || cap_rd[2] !== 1'b0) begin n_fail++; $display("FAIL sb_wait_t2: wr=%0b rd=%0b want 0/0", cap_wr[2], cap_rd[2]); end
        n_cmp++; if (cap_wr[3] !== 1'b1 || cap_wdata[3] !== 64'hFFFF_FFFF_ABFF_FFFF) begin n_fail++; $display("FAIL sb_wr_t3: wr=%0b wdata=%h want 1/FFFFFFFFABFFFFFF", cap_wr[3], cap_wdata[3]); end
        n_cmp++; if (cap_done[4] !== 1'b1 || cap_addr[4] !== 64'h10) begin n_fail++; $display("FAIL sb_done_t4: done=%0b addr=%h want 1/10", cap_done[4], cap_addr[4]); end
        n_cmp++; if (cap_rdy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_idle_t5: got %0b want 1", cap_rdy[5]); end
        settle();
    endtask

    task automatic test_sh_lat3();
        mem_val3 = 64'd0;
        drive(2'b10, 64'h16, 64'h0000_0000_0000_BEEF);
        capture(1, 7, 1'b0);
        n_cmp++; if (cap_rd[1] !== 1'b1) begin n_fail++; $display("FAIL sh3_rd_t1: got %0b want 1", cap_rd[1]); end
        n_cmp++; if (cap_wr[4] !== 1'b0) begin n_fail++; $display("FAIL sh3_early_wr_t4: got %0b want 0", cap_wr[4]); end
        n_cmp++; if (cap_wr[5] !== 1'b1 || cap_wdata[5] !== 64'hBEEF_0000_0000_0000) begin n_fail++; $display("FAIL sh3_wr_t5: wr=%0b wdata=%h want 1/BEEF000000000000", cap_wr[5], cap_wdata[5]); end
        n_cmp++; if (cap_done[6] !== 1'b1 || cap_rdy[7] !== 1'b1) begin n_fail++; $display("FAIL sh3_done: done6=%0b ready7=%0b want 1/1", cap_done[6], cap_rdy[7]); end
        settle();
    endtask

    task automatic test_sw_merge();
        mem_val1 = 64'h0123_4567_89AB_CDEF;
        drive(2'b01, 64'h24, 64'hCAFE_BABE_1234_5678);
        capture(0, 4, 1'b0);
        n_cmp++; if (cap_addr[1] !== 64'h20) begin n_fail++; $display("FAIL sw_addr: got %h want 20", cap_addr[1]); end
        n_cmp++; if (cap_wr[3] !== 1'b1 || cap_wdata[3] !== 64'h1234_5678_89AB_CDEF) begin n_fail++; $display("FAIL sw_merge: wr=%0b wdata=%h want 1/1234567889ABCDEF", cap_wr[3], cap_wdata[3]); end
        n_cmp++; if (cap_wdata[2] !== 64'd0 || cap_wdata[4] !== 64'd0) begin n_fail++; $display("FAIL sw_wdata_idle: got %h %h want 0", cap_wdata[2], cap_wdata[4]); end
        settle();
    endtask

    task automatic test_reset_mid();
        mem_val3 = 64'h5555_5555_5555_5555;
        drive(2'b11, 64'h08, 64'h0000_0000_0000_0055);
        tick(); req_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (st3 !== 3'd2) begin n_fail++; $display("FAIL rstmid_in_wait: state=%0d want 2", st3); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({rd1, wr1, rd3, wr3} !== 4'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %b want 0000", {rd1, wr1, rd3, wr3}); end
        n_cmp++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || addr3 !== 64'd0) begin n_fail++; $display("FAIL rstmid_idle: rdy=%0b%0b addr=%h want 11/0", rdy1, rdy3, addr3); end
        tick(); tick();
        rst_n = 1'b1;
        begin
            int wr_cnt;
            wr_cnt = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (wr1 || wr3) wr_cnt++;
            end
            n_cmp++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt); end
        end
    endtask
`else
    task automatic test_byte_en();
        drive(2'b11, 64'h13, 64'h0000_0000_0000_00AB);
        capture(0, 3, 1'b0);
        n_cmp++; if (cap_wr[1] !== 1'b1 || cap_be[1] !== 8'h08) begin n_fail++; $display("FAIL be_sb_wr: wr=%0b be=%h want 1/08", cap_wr[1], cap_be[1]); end
        n_cmp++; if (cap_wdata[1] !== 64'h0000_0000_AB00_0000) begin n_fail++; $display("FAIL be_sb_wdata: got %h want 00000000AB000000", cap_wdata[1]); end
        n_cmp++; if (cap_rd[1] || cap_rd[2] || cap_rd[3] || cap_done[2] !== 1'b1) begin n_fail++; $display("FAIL be_sb_rd_done: rd=%0b%0b%0b done2=%0b want 000/1", cap_rd[1], cap_rd[2], cap_rd[3], cap_done[2]); end
        settle();
        drive(2'b01, 64'h24, 64'hCAFE_BABE_1234_5678);
        capture(0, 2, 1'b0);
        n_cmp++; if (cap_be[1] !== 8'hF0 || cap_wdata[1] !== 64'h1234_5678_0000_0000) begin n_fail++; $display("FAIL be_sw: be=%h wdata=%h want F0/1234567800000000", cap_be[1], cap_wdata[1]); end
        n_cmp++; if (cap_be[2] !== 8'h00) begin n_fail++; $display("FAIL be_sw_idle: got %h want 00", cap_be[2]); end
        settle();
    endtask
`endif

    task automatic test_misaligned();
        logic [1:0]  sizes[3];
        logic [63:0] addrs[3];
        sizes = '{2'b01, 2'b10, 2'b00};
        addrs = '{64'h0A, 64'h13, 64'h14};
        for (int i = 0; i < 3; i++) begin
            drive(sizes[i], addrs[i], 64'h1234);
            capture(0, 2, 1'b0);
            n_cmp++; if (cap_done[1] !== 1'b1 || cap_err[1] !== 1'b1) begin n_fail++; $display("FAIL mis%0d_err_t1: done=%0b err=%0b want 1/1", i, cap_done[1], cap_err[1]); end
            n_cmp++; if ({cap_rd[1], cap_wr[1], cap_rd[2], cap_wr[2]} !== 4'b0) begin n_fail++; $display("FAIL mis%0d_no_mem: got %b want 0000", i, {cap_rd[1], cap_wr[1], cap_rd[2], cap_wr[2]}); end
            n_cmp++; if (cap_rdy[2] !== 1'b1 || cap_done[2] !== 1'b0 || cap_err[2] !== 1'b0) begin n_fail++; $display("FAIL mis%0d_idle_t2: ready=%0b done=%0b err=%0b want 1/0/0", i, cap_rdy[2], cap_done[2], cap_err[2]); end
            settle();
        end
    endtask

    task automatic test_back_to_back();
        drive(2'b00, 64'h40, 64'hA5A5_A5A5_5A5A_5A5A);
        capture(0, 5, 1'b1);
        n_cmp++; if ({cap_wr[1], cap_wr[2], cap_wr[3], cap_wr[4], cap_wr[5]} !== 5'b10010) begin n_fail++; $display("FAIL b2b_wr_pattern: got %b want 10010", {cap_wr[1], cap_wr[2], cap_wr[3], cap_wr[4], cap_wr[5]}); end
        n_cmp++; if (cap_rdy[1] !== 1'b0 || cap_rdy[2] !== 1'b0 || cap_rdy[3] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b%0b%0b want 001", cap_rdy[1], cap_rdy[2], cap_rdy[3]); end
        n_cmp++; if (cap_wdata[4] !== 64'hA5A5_A5A5_5A5A_5A5A || cap_done[5] !== 1'b1) begin n_fail++; $display("FAIL b2b_second: wdata=%h done5=%0b want A5A5A5A55A5A5A5A/1", cap_wdata[4], cap_done[5]); end
        settle();
    endtask

    initial begin
        test_reset();
        test_sd();
`ifndef STORE_MERGE_BYTE_EN_EN
        test_sb_lat1();
        test_sh_lat3();
        test_sw_merge();
`else
        test_byte_en();
`endif
        test_misaligned();
        test_back_to_back();
`ifndef STORE_MERGE_BYTE_EN_EN
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
